// File: rtl/if_stage_if.sv
// Instruction-memory port of the fetch stage: single-outstanding req/gnt/rvalid.
// The master side issues requests; the slave side is the instruction memory.
interface if_stage_if;
  logic        imemReq;
  logic [63:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemGnt,
    input  imemRvalid,
    input  imemRdata
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemGnt,
    output imemRvalid,
    output imemRdata
  );
endinterface

// File: rtl/if_stage.sv
// RV64 instruction fetch: PC owner, single-outstanding imem requests, IF/ID register + 1-entry skid.
// Response to instValid is 1 cycle; stallF holds IF/ID and parks late responses in the skid, no new request while it is full.
// Optional IF_MISALIGN_TRAP_EN: a misaligned redirect raises instMisalign instead of fetching.
module if_stage #(
  parameter logic [63:0] PC_RESET = 64'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallF,
  input  logic              flushF,
  input  logic [63:0]       jumpTarget,
  if_stage_if.master        imem,
  output logic              instValid,
  output logic [63:0]       instPc,
  output logic [31:0]       inst,
  output logic              instMisalign,
  output logic              fetchBusy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP_REQ,
    S_DROP_WAIT
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] r_addr;
  logic        r_valid;
  logic [63:0] r_inst_pc;
  logic [31:0] r_inst;
  logic        r_skid_vld;
  logic [63:0] r_skid_pc;
  logic [31:0] r_skid_inst;
  logic        r_misalign;
  logic        r_trap;

  logic [63:0] w_target;
  logic        w_target_bad;
  logic        w_trap_nxt;
  logic        w_can_issue;
  logic        w_deliver;
  state_t      w_resume;

`ifdef IF_MISALIGN_TRAP_EN
  assign w_target     = jumpTarget;
  assign w_target_bad = flushF && (jumpTarget[1:0] != 2'b00);
`else
  assign w_target     = jumpTarget & 64'hFFFF_FFFF_FFFF_FFFC;
  assign w_target_bad = 1'b0;
`endif

  assign w_trap_nxt  = flushF ? w_target_bad : r_trap;
  assign w_resume    = w_trap_nxt ? S_IDLE : S_REQ;
  assign w_can_issue = !r_skid_vld && !(stallF && r_valid) && !r_trap;
  assign w_deliver   = (r_state == S_WAIT) && imem.imemRvalid && !flushF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (flushF)           w_state_nxt = w_resume;
        else if (w_can_issue) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (imem.imemGnt) w_state_nxt = flushF ? S_DROP_WAIT : S_WAIT;
        else if (flushF)  w_state_nxt = S_DROP_REQ;
      end
      S_WAIT: begin
        if (flushF)                w_state_nxt = imem.imemRvalid ? w_resume : S_DROP_WAIT;
        else if (imem.imemRvalid)  w_state_nxt = w_can_issue ? S_REQ : S_IDLE;
      end
      S_DROP_REQ: begin
        if (imem.imemGnt) w_state_nxt = S_DROP_WAIT;
      end
      S_DROP_WAIT: begin
        if (imem.imemRvalid) w_state_nxt = w_resume;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_addr tracks the address of the last presented request: it is the PC of the
  // response in WAIT and the address that must stay on the bus in DROP_REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc   <= PC_RESET;
      r_addr <= PC_RESET;
    end else begin
      if (r_state == S_REQ) r_addr <= r_pc;
      if (flushF)                                   r_pc <= w_target;
      else if ((r_state == S_REQ) && imem.imemGnt)  r_pc <= r_pc + 64'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_inst_pc   <= 64'd0;
      r_inst      <= NOP_INST;
      r_skid_vld  <= 1'b0;
      r_skid_pc   <= 64'd0;
      r_skid_inst <= NOP_INST;
      r_misalign  <= 1'b0;
      r_trap      <= 1'b0;
    end else if (flushF) begin
      r_skid_vld <= 1'b0;
      r_misalign <= w_target_bad;
      r_trap     <= w_target_bad;
      r_valid    <= w_target_bad;
      r_inst     <= NOP_INST;
      if (w_target_bad) r_inst_pc <= jumpTarget;
    end else if (w_deliver) begin
      if (!r_valid || !stallF) begin
        r_valid   <= 1'b1;
        r_inst_pc <= r_addr;
        r_inst    <= imem.imemRdata;
      end else begin
        r_skid_vld  <= 1'b1;
        r_skid_pc   <= r_addr;
        r_skid_inst <= imem.imemRdata;
      end
    end else if (!stallF) begin
      if (r_skid_vld) begin
        r_valid    <= 1'b1;
        r_inst_pc  <= r_skid_pc;
        r_inst     <= r_skid_inst;
        r_skid_vld <= 1'b0;
      end else begin
        r_valid <= 1'b0;
        r_inst  <= NOP_INST;
      end
    end
  end

  assign imem.imemReq  = (r_state == S_REQ) || (r_state == S_DROP_REQ);
  assign imem.imemAddr = (r_state == S_DROP_REQ) ? r_addr : r_pc;
  assign fetchBusy     = (r_state != S_IDLE);
  assign instValid     = r_valid;
  assign instPc        = r_inst_pc;
  assign inst          = r_inst;
  assign instMisalign  = r_misalign;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed per-cycle vector table, reset/trap sequences, then
// random stall/flush/memory timing checked against the architectural PC stream seen by decode.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic Z = 1'b0;
  localparam logic O = 1'b1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallF = 1'b0;
  logic        flushF = 1'b0;
  logic [63:0] jumpTarget = 64'd0;
  logic        instValid, instMisalign, fetchBusy;
  logic [63:0] instPc;
  logic [31:0] inst;

  if_stage_if imem_if();

  if_stage dut (
    .clk(clk), .rst(rst), .stallF(stallF), .flushF(flushF), .jumpTarget(jumpTarget),
    .imem(imem_if), .instValid(instValid), .instPc(instPc), .inst(inst),
    .instMisalign(instMisalign), .fetchBusy(fetchBusy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // memory model state
  logic        p_req, p_gnt, outst;
  logic [63:0] p_addr, o_addr;
  int          dly;

  typedef struct {
    logic        stall, flush;
    logic [63:0] tgt;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        ereq;
    logic [63:0] eaddr;
    logic        evalid;
    logic [63:0] epc;
    logic [31:0] einst;
    logic        ebusy;
  } vec_t;

  vec_t tv[25];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; stallF = 1'b0; flushF = 1'b0;
    imem_if.imemGnt = 1'b0; imem_if.imemRvalid = 1'b0; imem_if.imemRdata = 32'd0;
    outst = 1'b0; p_req = 1'b0; p_gnt = 1'b0; p_addr = 64'd0; o_addr = 64'd0; dly = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [63:0] exp_pc, t;
    int consumed;

    imem_if.imemGnt = 1'b0; imem_if.imemRvalid = 1'b0; imem_if.imemRdata = 32'd0;
    outst = 1'b0; p_req = 1'b0; p_gnt = 1'b0; p_addr = 64'd0; o_addr = 64'd0; dly = 0;

    tv[0]  = '{Z,Z,64'd0,              O,Z,32'd0,         O,64'h8000_0000,Z,64'd0,         NOP,          O};
    tv[1]  = '{Z,Z,64'd0,              Z,O,32'h0010_0093, Z,64'd0,        Z,64'd0,         NOP,          O};
    tv[2]  = '{O,Z,64'd0,              O,Z,32'd0,         O,64'h8000_0004,O,64'h8000_0000, 32'h0010_0093,O};
    tv[3]  = '{O,Z,64'd0,              Z,O,32'h0020_0113, Z,64'd0,        O,64'h8000_0000, 32'h0010_0093,O};
    tv[4]  = '{O,Z,64'd0,              Z,Z,32'd0,         Z,64'd0,        O,64'h8000_0000, 32'h0010_0093,Z};
    tv[5]  = '{Z,Z,64'd0,              Z,Z,32'd0,         Z,64'd0,        O,64'h8000_0000, 32'h0010_0093,Z};
    tv[6]  = '{Z,Z,64'd0,              Z,Z,32'd0,         Z,64'd0,        O,64'h8000_0004, 32'h0020_0113,Z};
    tv[7]  = '{Z,Z,64'd0,              O,Z,32'd0,         O,64'h8000_0008,Z,64'd0,         NOP,          O};
    tv[8]  = '{Z,O,64'h8000_0100,      Z,Z,32'd0,         Z,64'd0,        Z,64'd0,         NOP,          O};
    tv[9]  = '{Z,Z,64'd0,              Z,O,32'hDEAD_BEEF, Z,64'd0,        Z,64'd0,         NOP,          O};
    tv[10] = '{Z,O,64'h8000_0200,      Z,Z,32'd0,         O,64'h8000_0100,Z,64'd0,         NOP,          O};
    tv[11] = '{Z,Z,64'd0,              Z,Z,32'd0,         O,64'h8000_0100,Z,64'd0,         NOP,          O};
    tv[12] = '{Z,Z,64'd0,              O,Z,32'd0,         O,64'h8000_0100,Z,64'd0,         NOP,          O};
    tv[13] = '{Z,Z,64'd0,              Z,O,32'hBAD0_0001, Z,64'd0,        Z,64'd0,         NOP,          O};
    tv[14] = '{Z,Z,64'd0,              O,Z,32'd0,         O,64'h8000_0200,Z,64'd0,         NOP,          O};
    tv[15] = '{Z,Z,64'd0,              Z,O,32'h0030_0193, Z,64'd0,        Z,64'd0,         NOP,          O};
    tv[16] = '{O,O,64'h8000_0300,      Z,Z,32'd0,         O,64'h8000_0204,O,64'h8000_0200, 32'h0030_0193,O};
    tv[17] = '{Z,Z,64'd0,              O,Z,32'd0,         O,64'h8000_0204,Z,64'd0,         NOP,          O};
    tv[18] = '{Z,Z,64'd0,              Z,O,32'hCAFE_0000, Z,64'd0,        Z,64'd0,         NOP,          O};
    tv[19] = '{Z,Z,64'd0,              O,Z,32'd0,         O,64'h8000_0300,Z,64'd0,         NOP,          O};
    tv[20] = '{Z,O,64'h8000_0400,      Z,O,32'h0BAD_0BAD, Z,64'd0,        Z,64'd0,         NOP,          O};
    tv[21] = '{Z,Z,64'd0,              O,Z,32'd0,         O,64'h8000_0400,Z,64'd0,         NOP,          O};
    tv[22] = '{Z,Z,64'd0,              Z,O,32'h0040_0213, Z,64'd0,        Z,64'd0,         NOP,          O};
    tv[23] = '{Z,Z,64'd0,              Z,Z,32'd0,         O,64'h8000_0404,O,64'h8000_0400, 32'h0040_0213,O};
    tv[24] = '{Z,Z,64'd0,              Z,Z,32'd0,         O,64'h8000_0404,Z,64'd0,         NOP,          O};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst.req",   {63'd0, imem_if.imemReq}, 64'd0);
    chk("rst.addr",  imem_if.imemAddr, 64'h8000_0000);
    chk("rst.valid", {63'd0, instValid}, 64'd0);
    chk("rst.pc",    instPc, 64'd0);
    chk("rst.inst",  {32'd0, inst}, {32'd0, NOP});
    chk("rst.mis",   {63'd0, instMisalign}, 64'd0);
    chk("rst.busy",  {63'd0, fetchBusy}, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      stallF = tv[i].stall; flushF = tv[i].flush; jumpTarget = tv[i].tgt;
      imem_if.imemGnt = tv[i].gnt; imem_if.imemRvalid = tv[i].rvalid; imem_if.imemRdata = tv[i].rdata;
      @(negedge clk);
      chk($sformatf("row%0d.req", i),   {63'd0, imem_if.imemReq}, {63'd0, tv[i].ereq});
      chk($sformatf("row%0d.busy", i),  {63'd0, fetchBusy}, {63'd0, tv[i].ebusy});
      chk($sformatf("row%0d.valid", i), {63'd0, instValid}, {63'd0, tv[i].evalid});
      chk($sformatf("row%0d.inst", i),  {32'd0, inst}, {32'd0, tv[i].einst});
      chk($sformatf("row%0d.mis", i),   {63'd0, instMisalign}, 64'd0);
      if (tv[i].ereq)   chk($sformatf("row%0d.addr", i), imem_if.imemAddr, tv[i].eaddr);
      if (tv[i].evalid) chk($sformatf("row%0d.pc", i), instPc, tv[i].epc);
    end

    // reset asserted mid-transaction, with DUT waiting on a response
    @(posedge clk); #1;
    stallF = 1'b0; flushF = 1'b0; imem_if.imemRvalid = 1'b0; imem_if.imemGnt = 1'b1;
    @(posedge clk); #1;
    imem_if.imemGnt = 1'b0;
    chk("mid.busy_before", {63'd0, fetchBusy}, 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid.req",   {63'd0, imem_if.imemReq}, 64'd0);
    chk("mid.addr",  imem_if.imemAddr, 64'h8000_0000);
    chk("mid.valid", {63'd0, instValid}, 64'd0);
    chk("mid.pc",    instPc, 64'd0);
    chk("mid.inst",  {32'd0, inst}, {32'd0, NOP});
    chk("mid.busy",  {63'd0, fetchBusy}, 64'd0);
    do_reset();
    @(posedge clk); #1;
    chk("mid.first_req", {63'd0, imem_if.imemReq}, 64'd1);

`ifdef IF_MISALIGN_TRAP_EN
    do_reset();
    @(posedge clk); #1;
    imem_if.imemGnt = 1'b1;
    @(posedge clk); #1;
    imem_if.imemGnt = 1'b0; imem_if.imemRvalid = 1'b1; imem_if.imemRdata = 32'h1111_1111;
    flushF = 1'b1; jumpTarget = 64'h8000_0102; stallF = 1'b1;
    @(posedge clk); #1;
    imem_if.imemRvalid = 1'b0; flushF = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("trap%0d.mis", k),   {63'd0, instMisalign}, 64'd1);
      chk($sformatf("trap%0d.valid", k), {63'd0, instValid}, 64'd1);
      chk($sformatf("trap%0d.pc", k),    instPc, 64'h8000_0102);
      chk($sformatf("trap%0d.inst", k),  {32'd0, inst}, {32'd0, NOP});
      chk($sformatf("trap%0d.req", k),   {63'd0, imem_if.imemReq}, 64'd0);
      @(posedge clk); #1;
    end
    flushF = 1'b1; jumpTarget = 64'h8000_0000;
    @(posedge clk); #1;
    flushF = 1'b0; stallF = 1'b0;
    @(negedge clk);
    chk("trap.clr_mis", {63'd0, instMisalign}, 64'd0);
    chk("trap.req",     {63'd0, imem_if.imemReq}, 64'd1);
    chk("trap.addr",    imem_if.imemAddr, 64'h8000_0000);
`endif

    // random phase: decode must see the sequential PC stream, restarted at each redirect
    do_reset();
    exp_pc = 64'h8000_0000;
    consumed = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (p_req && !p_gnt) begin
        chk("proto.req_hold",  {63'd0, imem_if.imemReq}, 64'd1);
        chk("proto.addr_hold", imem_if.imemAddr, p_addr);
      end
      if (p_req && p_gnt) begin
        outst = 1'b1; o_addr = p_addr; dly = $urandom_range(0, 2);
      end
      imem_if.imemRvalid = 1'b0;
      imem_if.imemRdata  = $urandom;
      if (outst) begin
        if (dly == 0) begin
          imem_if.imemRvalid = 1'b1;
          imem_if.imemRdata  = mem_word(o_addr);
          outst = 1'b0;
        end else begin
          dly--;
        end
      end
      imem_if.imemGnt = imem_if.imemReq && ($urandom_range(0, 2) != 0);
      stallF = ($urandom_range(0, 3) == 0);
      flushF = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) t = 64'hFFFF_FFFF_FFFF_FFF8;
      else t = {32'd0, 32'h8000_0000 + ($urandom_range(0, 255) << 2)};
`ifndef IF_MISALIGN_TRAP_EN
      t[1:0] = 2'($urandom_range(0, 3));
`endif
      jumpTarget = t;
      p_req = imem_if.imemReq; p_gnt = imem_if.imemGnt; p_addr = imem_if.imemAddr;
      @(negedge clk);
      if (flushF) begin
        exp_pc = jumpTarget & 64'hFFFF_FFFF_FFFF_FFFC;
      end else if (instValid && !stallF) begin
        chk("stream.pc",   instPc, exp_pc);
        chk("stream.inst", {32'd0, inst}, {32'd0, mem_word(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        consumed++;
      end else if (!instValid) begin
        chk("bubble.inst", {32'd0, inst}, {32'd0, NOP});
      end
    end
    chk("stream.progress", {63'd0, consumed > 150}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
